// File: rtl/psg_bus_pkg.sv
// Shared types for the YM2149/AY PSG bus master.
//   state_t    : bus sequencer states
//   BUS_*      : {BDIR,BC} encodings
//   psg_cmd_t  : queued register command {wr, addr, data}
`timescale 1ns/1ps
package psg_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_GAP1,
      ST_WR,
      ST_RD,
      ST_GAP2
   } state_t;

   localparam logic [1:0] BUS_IDLE  = 2'b00;
   localparam logic [1:0] BUS_READ  = 2'b01;
   localparam logic [1:0] BUS_WRITE = 2'b10;
   localparam logic [1:0] BUS_ADDR  = 2'b11;

   typedef struct packed {
      logic       wr;
      logic [3:0] addr;
      logic [7:0] data;
   } psg_cmd_t;

endpackage

// File: rtl/psg_cmd_fifo.sv
// Synchronous command FIFO for the PSG bus master.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   push_i/data_i : write request and command; accepted only while ready_o=1
//   ready_o       : registered "not full"
//   pop_i         : read request; ignored when empty
//   data_o        : head-of-queue command (valid when empty_o=0)
//   empty_o       : queue empty
`timescale 1ns/1ps
module psg_cmd_fifo
   import psg_bus_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  psg_cmd_t data_i,
   output logic     ready_o,
   input  logic     pop_i,
   output psg_cmd_t data_o,
   output logic     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic        ready_q;
   logic        do_push;
   logic        do_pop;
   logic        full_d;
   psg_cmd_t    mem_q [DEPTH];

   assign empty_o = (wptr_q == rptr_q);
   assign do_push = push_i & ready_q;
   assign do_pop  = pop_i & ~empty_o;

   assign wptr_d = wptr_q + {{AW{1'b0}}, do_push};
   assign rptr_d = rptr_q + {{AW{1'b0}}, do_pop};

   // Full when the pointers match except for the wrap bit.
   assign full_d = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ready_q <= ~full_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q[AW-1:0]] <= data_i;
      end
   end

   assign data_o  = mem_q[rptr_q[AW-1:0]];
   assign ready_o = ready_q;

endmodule

// File: rtl/psg_bus_master.sv
// Host-side BDIR/BC bus initiator for a YM2149/AY PSG.
// Commands enter through a valid/ready handshake into a FIFO and are played
// out as address / gap / data / gap bus phases, each held for HOLD_CYCLES
// CE-qualified cycles. The last latched register number is cached so repeated
// accesses to the same register can skip the address phase.
// Ports:
//   CLK, RESET           : clock, synchronous active-high reset
//   CE                   : bus pacing enable for the sequencer
//   CMD_VALID/READY      : command handshake; CMD_WR, CMD_ADDR, CMD_DATA
//   RD_VALID, RD_DATA    : one-CLK pulse and captured read value
//   BUSY                 : queue non-empty or sequencer active
//   BDIR, BC, PSG_DI     : registered PSG bus drive
//   PSG_DO               : PSG read data
`timescale 1ns/1ps
module psg_bus_master
   import psg_bus_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int HOLD_CYCLES = 1,
   parameter int ADDR_CACHE  = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       CE,
   input  logic       CMD_VALID,
   output logic       CMD_READY,
   input  logic       CMD_WR,
   input  logic [3:0] CMD_ADDR,
   input  logic [7:0] CMD_DATA,
   output logic       RD_VALID,
   output logic [7:0] RD_DATA,
   output logic       BUSY,
   output logic       BDIR,
   output logic       BC,
   output logic [7:0] PSG_DI,
   input  logic [7:0] PSG_DO
);

   localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] hold_q, hold_d;
   psg_cmd_t   cmd_q, cmd_d;
   logic [3:0] cache_q, cache_d;
   logic       cache_vld_q, cache_vld_d;
   logic [1:0] bus_q, bus_d;
   logic [7:0] di_q, di_d;
   logic [7:0] rd_data_q, rd_data_d;
   logic       rd_valid_q, rd_valid_d;

   logic       fifo_pop;
   logic       fifo_empty;
   psg_cmd_t   fifo_cmd;
   psg_cmd_t   push_cmd;

   assign push_cmd = {CMD_WR, CMD_ADDR, CMD_DATA};

   psg_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .push_i  (CMD_VALID),
      .data_i  (push_cmd),
      .ready_o (CMD_READY),
      .pop_i   (fifo_pop),
      .data_o  (fifo_cmd),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      cmd_d       = cmd_q;
      cache_d     = cache_q;
      cache_vld_d = cache_vld_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      fifo_pop    = 1'b0;
      bus_d       = BUS_IDLE;
      di_d        = 8'h00;

      if (CE) begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  cmd_d    = fifo_cmd;
                  hold_d   = HOLD_RELOAD;
                  // The PSG still holds the last latched register, so a
                  // matching address goes straight to the data phase.
                  if ((ADDR_CACHE != 0) && cache_vld_q && (fifo_cmd.addr == cache_q)) begin
                     state_d = fifo_cmd.wr ? ST_WR : ST_RD;
                  end else begin
                     state_d = ST_ADDR;
                  end
               end
            end
            ST_ADDR: begin
               if (hold_q == 4'd0) begin
                  state_d     = ST_GAP1;
                  cache_d     = cmd_q.addr;
                  cache_vld_d = 1'b1;
               end else begin
                  hold_d = hold_q - 4'd1;
               end
            end
            ST_GAP1: begin
               state_d = cmd_q.wr ? ST_WR : ST_RD;
               hold_d  = HOLD_RELOAD;
            end
            ST_WR: begin
               if (hold_q == 4'd0) begin
                  state_d = ST_GAP2;
               end else begin
                  hold_d = hold_q - 4'd1;
               end
            end
            ST_RD: begin
               if (hold_q == 4'd0) begin
                  // Sample while the read mode is still on the bus.
                  state_d    = ST_GAP2;
                  rd_data_d  = PSG_DO;
                  rd_valid_d = 1'b1;
               end else begin
                  hold_d = hold_q - 4'd1;
               end
            end
            ST_GAP2: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Bus drive is registered from the next state so it lines up with state_q.
      case (state_d)
         ST_ADDR: begin
            bus_d = BUS_ADDR;
            di_d  = {4'h0, cmd_d.addr};
         end
         ST_WR: begin
            bus_d = BUS_WRITE;
            di_d  = cmd_d.data;
         end
         ST_RD: begin
            bus_d = BUS_READ;
         end
         default: begin
            bus_d = BUS_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         hold_q      <= 4'd0;
         cache_vld_q <= 1'b0;
         bus_q       <= BUS_IDLE;
         di_q        <= 8'h00;
         rd_data_q   <= 8'h00;
         rd_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         cache_vld_q <= cache_vld_d;
         bus_q       <= bus_d;
         di_q        <= di_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   always_ff @(posedge CLK) begin
      cmd_q   <= cmd_d;
      cache_q <= cache_d;
   end

   assign BDIR     = bus_q[1];
   assign BC       = bus_q[0];
   assign PSG_DI   = di_q;
   assign RD_DATA  = rd_data_q;
   assign RD_VALID = rd_valid_q;
   assign BUSY     = ~fifo_empty | (state_q != ST_IDLE);

endmodule

// File: tb/tb_psg_bus_master.sv
`timescale 1ns/1ps
module tb_psg_bus_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT (HOLD_CYCLES=1, ADDR_CACHE=1) and a cache-disabled twin sharing its inputs
   logic       rst, ce, cmd_valid, cmd_wr;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       cmd_ready, rd_valid, busy, bdir, bc;
   logic [7:0] rd_data, psg_di, psg_do;
   logic       cmd_ready_nc, rd_valid_nc, busy_nc, bdir_nc, bc_nc;
   logic [7:0] rd_data_nc, psg_di_nc;
   // HOLD_CYCLES=3 DUT with its own command side and CE
   logic       ce3, cmd_valid3, cmd_wr3;
   logic [3:0] cmd_addr3;
   logic [7:0] cmd_data3;
   logic       cmd_ready3, rd_valid3, busy3, bdir3, bc3;
   logic [7:0] rd_data3, psg_di3;

   psg_bus_master #(.FIFO_DEPTH(16), .HOLD_CYCLES(1), .ADDR_CACHE(1)) u_dut (
      .CLK(clk), .RESET(rst), .CE(ce), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
      .CMD_WR(cmd_wr), .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .RD_VALID(rd_valid),
      .RD_DATA(rd_data), .BUSY(busy), .BDIR(bdir), .BC(bc), .PSG_DI(psg_di), .PSG_DO(psg_do));

   psg_bus_master #(.FIFO_DEPTH(16), .HOLD_CYCLES(1), .ADDR_CACHE(0)) u_nc (
      .CLK(clk), .RESET(rst), .CE(ce), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready_nc),
      .CMD_WR(cmd_wr), .CMD_ADDR(cmd_addr), .CMD_DATA(cmd_data), .RD_VALID(rd_valid_nc),
      .RD_DATA(rd_data_nc), .BUSY(busy_nc), .BDIR(bdir_nc), .BC(bc_nc), .PSG_DI(psg_di_nc),
      .PSG_DO(psg_do));

   psg_bus_master #(.FIFO_DEPTH(16), .HOLD_CYCLES(3), .ADDR_CACHE(1)) u_h3 (
      .CLK(clk), .RESET(rst), .CE(ce3), .CMD_VALID(cmd_valid3), .CMD_READY(cmd_ready3),
      .CMD_WR(cmd_wr3), .CMD_ADDR(cmd_addr3), .CMD_DATA(cmd_data3), .RD_VALID(rd_valid3),
      .RD_DATA(rd_data3), .BUSY(busy3), .BDIR(bdir3), .BC(bc3), .PSG_DI(psg_di3),
      .PSG_DO(8'h00));

   int checks = 0;
   int errors = 0;

   // Scoreboard: expected bus phases {mode, PSG_DI} and expected read data
   logic [9:0] exp_q [$];
   logic [7:0] rd_q  [$];
   logic [7:0] exp_regs [16];
   logic [3:0] m_cache;
   logic       m_cache_vld;

   // PSG register model driven by the main DUT bus
   logic [7:0] psg_regs [16];
   logic [3:0] psg_latch;
   assign psg_do = psg_regs[psg_latch];

   initial begin : psg_model
      forever begin
         @(posedge clk);
         if (rst) begin
            for (int i = 0; i < 16; i++) psg_regs[i] <= 8'h00;
            psg_regs[0] <= 8'hA5;
            psg_latch   <= 4'h0;
         end else if ({bdir, bc} == 2'b11) begin
            psg_latch <= psg_di[3:0];
         end else if ({bdir, bc} == 2'b10) begin
            psg_regs[psg_latch] <= psg_di;
         end
      end
   end

   int acc_cnt = 0;
   initial begin : accept_counter
      forever begin
         @(posedge clk);
         if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
      end
   end

   int         nc_addr_cnt = 0;
   int         nc_rdv_cnt  = 0;
   logic [7:0] nc_last_addr = 8'h00;
   initial begin : nc_monitor
      logic [1:0] nc_prev;
      nc_prev = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if ({bdir_nc, bc_nc} == 2'b11 && nc_prev != 2'b11) begin
               nc_addr_cnt++;
               nc_last_addr = psg_di_nc;
            end
            if (rd_valid_nc) nc_rdv_cnt++;
         end
         nc_prev = {bdir_nc, bc_nc};
      end
   end

   initial begin : main_monitor
      logic [9:0] cur, prev, e;
      logic [7:0] er;
      logic       prev_rdv;
      prev = 10'h000;
      prev_rdv = 1'b0;
      forever begin
         @(negedge clk);
         cur = {bdir, bc, psg_di};
         if (!rst) begin
            if (cur[9:8] != 2'b00 && cur != prev) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL phase_unexpected got=%h required=none", cur);
               end else begin
                  e = exp_q.pop_front();
                  if (cur !== e) begin
                     errors++;
                     $display("FAIL phase got=%h required=%h", cur, e);
                  end
               end
               checks++;
               if (prev[9:8] !== 2'b00) begin
                  errors++;
                  $display("FAIL phase_abut prev_mode=%b required=00", prev[9:8]);
               end
            end
            if (rd_valid) begin
               checks++;
               if (rd_q.size() == 0) begin
                  errors++;
                  $display("FAIL rd_unexpected rd_data=%h required=none", rd_data);
               end else begin
                  er = rd_q.pop_front();
                  if (rd_data !== er) begin
                     errors++;
                     $display("FAIL rd_data got=%h required=%h", rd_data, er);
                  end
               end
               checks++;
               if (prev[9:8] !== 2'b01 || cur[9:8] !== 2'b00 || prev_rdv !== 1'b0) begin
                  errors++;
                  $display("FAIL rd_valid_timing prev=%b cur=%b prev_rdv=%b required 01/00/0",
                           prev[9:8], cur[9:8], prev_rdv);
               end
            end
         end
         prev = cur;
         prev_rdv = rd_valid;
      end
   end

   task automatic push(input logic wr, input logic [3:0] a, input logic [7:0] d);
      int n;
      if (!(m_cache_vld && m_cache == a)) begin
         exp_q.push_back({2'b11, 4'h0, a});
         m_cache     = a;
         m_cache_vld = 1'b1;
      end
      if (wr) begin
         exp_q.push_back({2'b10, d});
         exp_regs[a] = d;
      end else begin
         exp_q.push_back({2'b01, 8'h00});
         rd_q.push_back(exp_regs[a]);
      end
      cmd_valid = 1'b1;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_data  = d;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout ready=%b required=1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || busy_nc || busy3) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy || busy_nc || busy3) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout busy=%b%b%b required=000", busy, busy_nc, busy3);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic busy_len(input int req, input string nm);
      int n;
      n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== req) begin
         errors++;
         $display("FAIL %s busy_cycles=%0d required=%0d", nm, n, req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 4'h0; cmd_data = 8'h00;
      ce3 = 1'b1; cmd_valid3 = 1'b0; cmd_wr3 = 1'b0; cmd_addr3 = 4'h0; cmd_data3 = 8'h00;
      m_cache = 4'h0; m_cache_vld = 1'b0;
      for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
      exp_regs[0] = 8'hA5;
      repeat (3) @(negedge clk);
      checks++;
      if ({bdir, bc} !== 2'b00) begin errors++; $display("FAIL reset_bus got=%b required=00", {bdir, bc}); end
      checks++;
      if (psg_di !== 8'h00) begin errors++; $display("FAIL reset_di got=%h required=00", psg_di); end
      checks++;
      if ({rd_valid, rd_data} !== 9'h000) begin errors++; $display("FAIL reset_rd got=%b/%h required=0/00", rd_valid, rd_data); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b required=0", cmd_ready); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got=%b required=1", cmd_ready); end
   endtask

   task automatic test_write_uncached();
      push(1'b1, 4'h7, 8'h38);
      busy_len(5, "uncached_write");
      checks++;
      if (psg_regs[7] !== 8'h38) begin errors++; $display("FAIL psg_reg7 got=%h required=38", psg_regs[7]); end
      wait_idle();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL phases_left got=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_cache();
      int base;
      base = nc_addr_cnt;
      push(1'b1, 4'h7, 8'h38);
      busy_len(3, "cached_write1");
      push(1'b1, 4'h7, 8'h3F);
      busy_len(3, "cached_write2");
      wait_idle();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL cache_phases_left got=%0d required=0", exp_q.size()); end
      checks++;
      if (psg_regs[7] !== 8'h3F) begin errors++; $display("FAIL psg_reg7_cached got=%h required=3F", psg_regs[7]); end
      checks++;
      if (nc_addr_cnt - base !== 2) begin errors++; $display("FAIL nocache_addr_phases got=%0d required=2", nc_addr_cnt - base); end
      checks++;
      if (nc_last_addr !== 8'h07) begin errors++; $display("FAIL nocache_addr_di got=%h required=07", nc_last_addr); end
   endtask

   task automatic test_read();
      int base;
      base = nc_rdv_cnt;
      push(1'b0, 4'h0, 8'h00);
      wait_idle();
      checks++;
      if (rd_q.size() != 0) begin errors++; $display("FAIL read_pending got=%0d required=0", rd_q.size()); end
      checks++;
      if (rd_data !== 8'hA5) begin errors++; $display("FAIL rd_data got=%h required=A5", rd_data); end
      push(1'b1, 4'h3, 8'h5A);
      wait_idle();
      checks++;
      if (rd_data !== 8'hA5) begin errors++; $display("FAIL rd_data_hold got=%h required=A5", rd_data); end
      checks++;
      if (rd_data_nc !== 8'hA5) begin errors++; $display("FAIL nocache_rd_data got=%h required=A5", rd_data_nc); end
      checks++;
      if (nc_rdv_cnt - base !== 1) begin errors++; $display("FAIL nocache_rd_pulses got=%0d required=1", nc_rdv_cnt - base); end
   endtask

   task automatic test_fifo_full();
      int base;
      base = acc_cnt;
      ce = 1'b0;
      for (int i = 0; i < 16; i++) push(1'b1, 4'(i), 8'(8'h10 + i));
      checks++;
      if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b required=0", cmd_ready); end
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'h1; cmd_data = 8'hEE;
      repeat (3) @(negedge clk);
      checks++;
      if (acc_cnt - base !== 16) begin errors++; $display("FAIL accepted got=%0d required=16", acc_cnt - base); end
      checks++;
      if ({cmd_ready, cmd_ready_nc} !== 2'b00) begin errors++; $display("FAIL full_ready_hold got=%b required=00", {cmd_ready, cmd_ready_nc}); end
      cmd_valid = 1'b0;
      ce = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got=%b required=1", cmd_ready); end
      wait_idle();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL fifo_phases_left got=%0d required=0", exp_q.size()); end
      checks++;
      if (psg_regs[15] !== 8'h1F) begin errors++; $display("FAIL psg_reg15 got=%h required=1F", psg_regs[15]); end
   endtask

   task automatic test_hold3();
      logic [9:0] cur, prev3;
      logic [9:0] exp3 [2];
      logic       ce_prev;
      int         run, runs;
      exp3[0] = {2'b11, 8'h05};
      exp3[1] = {2'b10, 8'h55};
      cmd_valid3 = 1'b1; cmd_wr3 = 1'b1; cmd_addr3 = 4'h5; cmd_data3 = 8'h55; ce3 = 1'b1;
      @(negedge clk);
      cmd_valid3 = 1'b0;
      prev3 = {bdir3, bc3, psg_di3};
      ce_prev = 1'b1;
      run = 0;
      runs = 0;
      for (int c = 0; c < 80; c++) begin
         cur = {bdir3, bc3, psg_di3};
         if (c > 0 && !ce_prev) begin
            checks++;
            if (cur !== prev3) begin errors++; $display("FAIL hold_stable cyc=%0d got=%h required=%h", c, cur, prev3); end
         end
         if (cur != prev3 && prev3[9:8] != 2'b00) begin
            checks++;
            if (runs >= 2 || run !== 3 || prev3 !== exp3[runs]) begin
               errors++;
               $display("FAIL hold_phase run=%0d len=%0d val=%h required len=3", runs, run, prev3);
            end
            runs++;
            run = 0;
         end
         ce3 = (c % 2 == 0);
         if (cur[9:8] != 2'b00 && ce3) run++;
         prev3 = cur;
         ce_prev = ce3;
         @(negedge clk);
      end
      ce3 = 1'b1;
      checks++;
      if (runs !== 2) begin errors++; $display("FAIL hold_runs got=%0d required=2", runs); end
      checks++;
      if ({busy3, rd_valid3, rd_data3} !== 10'h000) begin
         errors++;
         $display("FAIL hold_end busy=%b rdv=%b rd=%h required 0/0/00", busy3, rd_valid3, rd_data3);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      push(1'b1, 4'h9, 8'h99);
      n = 0;
      while ({bdir, bc} !== 2'b10 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if ({bdir, bc} !== 2'b10) begin errors++; $display("FAIL wr_phase_timeout got=%b required=10", {bdir, bc}); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bdir, bc, busy, rd_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL abort bdir_bc=%b busy=%b rdv=%b required 00/0/0", {bdir, bc}, busy, rd_valid);
      end
      rst = 1'b0;
      m_cache_vld = 1'b0;
      for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
      exp_regs[0] = 8'hA5;
      @(negedge clk);
      push(1'b1, 4'h9, 8'h77);
      wait_idle();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL abort_phases_left got=%0d required=0", exp_q.size()); end
      checks++;
      if (psg_regs[9] !== 8'h77) begin errors++; $display("FAIL psg_reg9 got=%h required=77", psg_regs[9]); end
   endtask

   initial begin
      test_reset();
      test_write_uncached();
      test_cache();
      test_read();
      test_fifo_full();
      test_hold3();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
